// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// product_accumulator : sums a frame of 8-bit multiplier products and presents
// sum/count/overflow on a valid/ready output. Optional macro: ACC_SAT_EN.
// Rev 1.0
// ============================================================================
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sum;
  logic [LEN_W-1:0] count_inc;
  logic             beat_ok;

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign beat_ok   = in_valid && in_ready;
  // One extra bit so the carry out of the accumulator is visible.
  assign sum       = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, in_prod};
  assign count_inc = count_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (beat_ok) begin
          count_d = count_inc;
          ovf_d   = ovf_q | sum[ACC_W];
`ifdef ACC_SAT_EN
          // Once clamped the register sits at ACC_MAX, so any later add carries again.
          acc_d   = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
`else
          acc_d   = sum[ACC_W-1:0];
`endif
          if (in_last || (count_inc == CNT_MAX)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// tb_product_accumulator : directed and random frames against a sum/count model.
// Rev 1.0
// ============================================================================
module tb_product_accumulator;

  localparam int ACC_W = 10;
  localparam int LEN_W = 4;
  localparam int MAXV  = (1 << ACC_W) - 1;
  localparam int MAXLEN = (1 << LEN_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [LEN_W-1:0] out_count;
  logic             out_ovf;

  int n_cmp = 0;
  int n_err = 0;
  int m_sum = 0;
  int m_cnt = 0;

  product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: the true (unbounded) frame sum, reduced by the overflow rule.
  function automatic int model_acc(input int s);
`ifdef ACC_SAT_EN
    return (s > MAXV) ? MAXV : s;
`else
    return s % (MAXV + 1);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] p, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    m_sum += int'(p);
    m_cnt++;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("acc_after_beat", 32'(out_acc), 32'(model_acc(m_sum)));
    chk("count_after_beat", 32'(out_count), 32'(m_cnt));
    chk("valid_after_beat", {31'd0, out_valid}, {31'd0, (last || m_cnt == MAXLEN)});
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      in_prod = 8'($urandom);
      tick();
      chk("acc_idle", 32'(out_acc), 32'(model_acc(m_sum)));
      chk("count_idle", 32'(out_count), 32'(m_cnt));
    end
  endtask

  task automatic take_result(input int delay);
    int n;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("out_valid_frame", {31'd0, out_valid}, 32'd1);
    chk("out_acc_frame", 32'(out_acc), 32'(model_acc(m_sum)));
    chk("out_count_frame", 32'(out_count), 32'(m_cnt));
    chk("out_ovf_frame", {31'd0, out_ovf}, {31'd0, (m_sum > MAXV)});
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    repeat (delay) begin
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_acc", 32'(out_acc), 32'(model_acc(m_sum)));
      chk("hold_count", 32'(out_count), 32'(m_cnt));
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    chk("valid_after_hs", {31'd0, out_valid}, 32'd0);
    chk("acc_after_hs", 32'(out_acc), 32'd0);
    chk("count_after_hs", 32'(out_count), 32'd0);
    chk("ovf_after_hs", {31'd0, out_ovf}, 32'd0);
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int len;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_acc", 32'(out_acc), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a frame
    repeat (3) send_beat(8'd100, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_acc", 32'(out_acc), 32'd0);
    chk("midrst_count", 32'(out_count), 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    #1;
    chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
    send_beat(8'd7, 1'b1);
    take_result(0);

    // Basic frame, out_ready high while accumulating (ignored until DONE)
    out_ready = 1'b1;
    send_beat(8'd225, 1'b0);
    send_beat(8'd12, 1'b0);
    send_beat(8'd0, 1'b0);
    send_beat(8'd10, 1'b1);
    chk("basic_acc_247", 32'(out_acc), 32'd247);
    take_result(0);
    send_beat(8'd3, 1'b1);
    take_result(0);

    // Backpressure
    send_beat(8'd40, 1'b0);
    send_beat(8'd50, 1'b1);
    in_valid = 1'b1;
    in_prod  = 8'd77;
    take_result(5);
    in_valid = 1'b0;

    // Length limit: 15 beats with no in_last closes the frame
    repeat (MAXLEN) send_beat(8'd1, 1'b0);
    chk("len_count_15", 32'(out_count), 32'd15);
    in_valid = 1'b1;
    in_prod  = 8'd1;
    take_result(2);
    send_beat(8'd1, 1'b1);
    take_result(0);

    // Overflow with ACC_W=10: 5 x 225 = 1125
    repeat (4) send_beat(8'd225, 1'b0);
    send_beat(8'd225, 1'b1);
`ifdef ACC_SAT_EN
    chk("ovf_acc_sat", 32'(out_acc), 32'd1023);
`else
    chk("ovf_acc_wrap", 32'(out_acc), 32'd101);
`endif
    chk("ovf_flag", {31'd0, out_ovf}, 32'd1);
    take_result(1);
    send_beat(8'd9, 1'b1);
    chk("next_frame_ovf_clear", {31'd0, out_ovf}, 32'd0);
    take_result(0);

    // Bubbles: valid 1,0,0,1,0,1(last)
    send_beat(8'd5, 1'b0);
    idle(2);
    send_beat(8'd9, 1'b0);
    idle(1);
    send_beat(8'd2, 1'b1);
    chk("bubble_acc_16", 32'(out_acc), 32'd16);
    take_result(0);

    // Random frames
    for (int f = 0; f < 12; f++) begin
      len = int'($urandom_range(1, MAXLEN));
      for (int i = 0; i < len; i++) begin
        out_ready = 1'($urandom);
        idle(int'($urandom_range(0, 2)));
        send_beat(8'($urandom_range(0, 255)), (i == len - 1));
      end
      take_result(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
